mac_dot_ctrl: RTL and testbench



---
 rtl/mac_pkg.sv | 6 +
 rtl/mac_dp.sv | 38 +++
 rtl/mac_dot_ctrl.sv | 61 ++++++
 tb/tb_mac_dot_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and widths for the dot-product MAC sequencer
package mac_pkg;
  localparam int OP_W = 8;
  localparam int DEF_ACC_W = 17;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_dp.sv
// mac_dp: registered 8x8 product stage feeding a wrapping accumulator with sticky carry
module mac_dp
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             prod_en,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  logic [2*OP_W-1:0] prod_q;
  logic              prod_v;
  logic [ACC_W:0]    sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      prod_v <= prod_en;
      if (prod_en) prod_q <= op_a * op_b;
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (prod_v) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
      end
    end
  end
endmodule

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: job sequencer streaming operand pairs into mac_dp and presenting the sum
module mac_dot_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);
  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             hs;
  logic             clr;
  assign op_ready  = state == RUN;
  assign busy      = state != IDLE;
  assign res_valid = state == DONE;
  assign hs        = op_valid & op_ready;
  assign clr       = (state == IDLE) & start;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= (len != '0) ? RUN : DONE;
          remaining <= len;
        end
        RUN: if (hs) begin
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  mac_dp #(.ACC_W(ACC_W)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .prod_en (hs),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc     (result),
    .ovf     (ovf)
  );
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: directed and randomized jobs checked against an arithmetic dot-product model
module tb_mac_dot_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, op_valid, res_ready;
  logic [3:0]  len;
  logic [7:0]  op_a, op_b;
  logic        busy, op_ready, res_valid, ovf;
  logic [16:0] result;
  int n_tests = 0;
  int n_fail = 0;
  int qa[16];
  int qb[16];

  always #5 clk = ~clk;

  mac_dot_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // gap >= 0: fixed idle cycles between pairs; gap < 0: random idle cycles
  task automatic run_job(input int n, input int gap, input int hold);
    longint total = 0;
    int idx = 0, w = 0, cyc = 0;
    logic idle;
    for (int i = 0; i < n; i++) total += longint'(qa[i] * qb[i]);
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1;
    len = 4'(n);
    op_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len = 4'($urandom);
    check("busy_after_start", busy, 1);
    if (n != 0) begin
      while (idx < n && cyc < 400) begin
        check("op_ready_run", op_ready, 1);
        idle = (gap >= 0) ? (idx > 0 && w < gap) : ($urandom_range(0, 2) == 0);
        op_valid = !idle;
        op_a = idle ? 8'($urandom) : 8'(qa[idx]);
        op_b = idle ? 8'($urandom) : 8'(qb[idx]);
        if (!idle) begin
          idx++;
          w = 0;
        end else w++;
        @(negedge clk);
        cyc++;
      end
      check("accepted_pairs", idx, n);
      op_valid = 1'b1;
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      check("drain_op_ready", op_ready, 0);
      check("drain_res_valid", res_valid, 0);
      check("drain_busy", busy, 1);
      @(negedge clk);
    end
    check("done_res_valid", res_valid, 1);
    check("done_op_ready", op_ready, 0);
    check("result", result, 32'(total % 131072));
    check("ovf", ovf, (total >= 131072) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = 1'b1;
      len = 4'($urandom_range(1, 15));
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_result", result, 32'(total % 131072));
      check("hold_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    op_valid = 1'b0;
    check("back_idle_busy", busy, 0);
    check("back_idle_res_valid", res_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    qa[0] = 2; qb[0] = 3; qa[1] = 4; qb[1] = 5; qa[2] = 255; qb[2] = 255;
    run_job(3, 0, 0);
    for (int i = 0; i < 15; i++) begin
      qa[i] = 255;
      qb[i] = 255;
    end
    run_job(15, 0, 0);
    qa[0] = 10; qb[0] = 10; qa[1] = 10; qb[1] = 10;
    run_job(2, 3, 0);
    run_job(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      qa[i] = $urandom_range(0, 255);
      qb[i] = $urandom_range(0, 255);
    end
    run_job(4, 0, 5);
    @(negedge clk);
    start = 1'b1;
    len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    op_a = 8'd200;
    op_b = 8'd200;
    @(negedge clk);
    op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midjob_rst_busy", busy, 0);
    check("midjob_rst_op_ready", op_ready, 0);
    check("midjob_rst_res_valid", res_valid, 0);
    check("midjob_rst_result", result, 0);
    repeat (3) @(negedge clk);
    check("midjob_rst_quiet", res_valid, 0);
    qa[0] = 7; qb[0] = 9;
    run_job(1, 0, 0);
    for (int j = 0; j < 20; j++) begin
      int n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        qa[i] = $urandom_range(0, 255);
        qb[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      end
      run_job(n, -1, $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
